// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues word reads to a
// 1-cycle-latency instruction SRAM, and queues {pc, instr, adef} entries
// for decode behind a valid/ready handshake. Redirects flush the queue and
// drop wrong-path responses. A misaligned redirect target produces one ADEF
// entry and halts fetch until the next aligned redirect.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h1c000000,
   parameter int          DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = 32'h03400000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        inst_sram_en,
   output logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        out_adef
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   // control state
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic             inflight_q, inflight_d;
   logic             halted_q, halted_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // data state (never reset; qualified by count/inflight)
   logic [31:0]      inflight_pc_q, inflight_pc_d;
   logic [31:0]      fifo_pc_q    [DEPTH];
   logic [31:0]      fifo_instr_q [DEPTH];
   logic             fifo_adef_q  [DEPTH];

   // FIFO write port
   logic             wr_en;
   logic [PTR_W-1:0] wr_idx;
   logic [31:0]      wr_pc;
   logic [31:0]      wr_instr;
   logic             wr_adef;

   logic             redir_aligned;
   logic             pop;
   logic             resp_push;
   logic             seq_issue;
   logic [CNT_W:0]   occupancy;

   assign redir_aligned = redirect_valid & (redirect_pc[1:0] == 2'b00);

   // Head is exposed straight from the FIFO registers; zeroed when empty or in reset
   assign out_valid = ~reset & (count_q != '0);
   assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0;
   assign out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
   assign out_adef  = out_valid ? fifo_adef_q[rd_ptr_q]  : 1'b0;

   // A redirect cancels any consumption of the head in the same cycle
   assign pop = out_valid & out_ready & ~redirect_valid;

   // Responses are dropped when a redirect or reset lands in their return cycle
   assign resp_push = inflight_q & ~redirect_valid & ~reset;

   // Slots already committed (buffered + returning) minus the one leaving now;
   // pop implies count >= 1, so this never underflows
   assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
   assign seq_issue = ~halted_q & (occupancy < (CNT_W+1)'(DEPTH));

   assign inst_sram_en   = ~reset & (redirect_valid ? redir_aligned : seq_issue);
   assign inst_sram_addr = redirect_valid ? redirect_pc : fetch_pc_q;

   // Next-state selection for fetch PC, in-flight tracking and FIFO pointers
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      halted_d      = halted_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      wr_en         = 1'b0;
      wr_idx        = wr_ptr_q;
      wr_pc         = inflight_pc_q;
      wr_instr      = inst_sram_rdata;
      wr_adef       = 1'b0;
      if (redirect_valid) begin
         // flush everything queued; the returning response is wrong-path
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         if (redir_aligned) begin
            fetch_pc_d    = redirect_pc + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = redirect_pc;
            halted_d      = 1'b0;
         end else begin
            halted_d = 1'b1;
            wr_en    = 1'b1;
            wr_idx   = '0;
            wr_pc    = redirect_pc;
            wr_instr = NOP_INSTR;
            wr_adef  = 1'b1;
            wr_ptr_d = PTR_W'(1);
            count_d  = CNT_W'(1);
         end
      end else begin
         if (seq_issue) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
         end
         if (inflight_q) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(inflight_q) - CNT_W'(pop);
      end
   end

   // Control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         inflight_q <= 1'b0;
         halted_q   <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         halted_q   <= halted_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Data registers: in-flight PC tag and FIFO entry storage
   always_ff @(posedge clk) begin
      inflight_pc_q <= inflight_pc_d;
      if (wr_en && !reset) begin
         fifo_pc_q[wr_idx]    <= wr_pc;
         fifo_instr_q[wr_idx] <= wr_instr;
         fifo_adef_q[wr_idx]  <= wr_adef;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: SRAM model returning addr ^ 32'hFFFF0000,
// a scoreboard queue of expected decode entries, and per-scenario tasks.
module tb_if_fetch_stage;

   localparam logic [31:0] RESET_PC  = 32'h1c000000;
   localparam int          DEPTH     = 2;
   localparam logic [31:0] NOP_INSTR = 32'h03400000;

   logic        clk;
   logic        reset;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_adef;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adef;
   } entry_t;

   entry_t      exp_q[$];
   logic [31:0] exp_fetch;
   int          vectors;
   int          miscompares;

   if_fetch_stage #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH),
      .NOP_INSTR(NOP_INSTR)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .inst_sram_en   (inst_sram_en),
      .inst_sram_addr (inst_sram_addr),
      .inst_sram_rdata(inst_sram_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_adef       (out_adef)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous SRAM, 1-cycle read latency
   always @(posedge clk) begin
      inst_sram_rdata <= inst_sram_addr ^ 32'hFFFF0000;
   end

   task automatic fill(input logic [31:0] start);
      entry_t e;
      exp_q.delete();
      for (int i = 0; i < 64; i++) begin
         e.pc    = start + 32'(4 * i);
         e.instr = e.pc ^ 32'hFFFF0000;
         e.adef  = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic push_adef(input logic [31:0] pc);
      entry_t e;
      exp_q.delete();
      e.pc    = pc;
      e.instr = NOP_INSTR;
      e.adef  = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   // advance to the sampling edge and run the scoreboard on what the DUT shows
   task automatic tick();
      entry_t e;
      @(negedge clk);
      if (reset === 1'b0) begin
         if (inst_sram_en === 1'b1 && redirect_valid === 1'b0) begin
            vectors++;
            if (inst_sram_addr !== exp_fetch) begin
               miscompares++;
               $display("FAIL fetch_addr: got %h, want %h", inst_sram_addr, exp_fetch);
            end
            exp_fetch = exp_fetch + 32'd4;
         end
         if (out_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_out: got pc %h with nothing expected", out_pc);
            end else begin
               e = exp_q[0];
               if (out_pc !== e.pc || out_instr !== e.instr || out_adef !== e.adef) begin
                  miscompares++;
                  $display("FAIL head: got pc=%h instr=%h adef=%b, want pc=%h instr=%h adef=%b",
                           out_pc, out_instr, out_adef, e.pc, e.instr, e.adef);
               end
               if (out_ready === 1'b1 && redirect_valid === 1'b0) void'(exp_q.pop_front());
            end
         end
         vectors++;
         if (dut.resp_push && dut.count_q == DEPTH) begin
            miscompares++;
            $display("FAIL push_full: got push with count %0d, want no push", dut.count_q);
         end
      end
   endtask

   task automatic test_reset();
      drive_edge();
      tick();
      vectors++;
      if ({out_valid, out_pc, out_instr, out_adef, inst_sram_en} !== 67'h0) begin
         miscompares++;
         $display("FAIL reset_outs: got v=%b pc=%h instr=%h adef=%b en=%b, want all 0",
                  out_valid, out_pc, out_instr, out_adef, inst_sram_en);
      end
      drive_edge();
      reset = 1'b0;
      fill(RESET_PC);
      exp_fetch = RESET_PC;
      for (int c = 0; c < 6; c++) begin
         tick();
         vectors++;
         if (out_valid !== (c >= 2)) begin
            miscompares++;
            $display("FAIL first_valid c%0d: got %b, want %b", c, out_valid, (c >= 2));
         end
         if (c == 0) begin
            vectors++;
            if (inst_sram_en !== 1'b1 || inst_sram_addr !== RESET_PC) begin
               miscompares++;
               $display("FAIL first_req: got en=%b addr=%h, want en=1 addr=%h",
                        inst_sram_en, inst_sram_addr, RESET_PC);
            end
         end
         if (c >= 2) begin
            vectors++;
            if (out_pc !== RESET_PC + 32'(4 * (c - 2))) begin
               miscompares++;
               $display("FAIL stream_pc c%0d: got %h, want %h", c, out_pc, RESET_PC + 32'(4 * (c - 2)));
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] hold_pc;
      drive_edge();
      out_ready = 1'b0;
      hold_pc = exp_q[0].pc;
      for (int i = 0; i < 6; i++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_pc !== hold_pc || inst_sram_en !== 1'b0) begin
            miscompares++;
            $display("FAIL stall c%0d: got v=%b pc=%h en=%b, want v=1 pc=%h en=0",
                     i, out_valid, out_pc, inst_sram_en, hold_pc);
         end
         if (i >= 1) begin
            vectors++;
            if (dut.count_q !== DEPTH) begin
               miscompares++;
               $display("FAIL stall_count: got %0d, want %0d", dut.count_q, DEPTH);
            end
         end
      end
      drive_edge();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL resume_gap c%0d: got out_valid=%b, want 1", i, out_valid);
         end
      end
   endtask

   task automatic test_redirect_full();
      drive_edge();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      drive_edge();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h1c000100;
      out_ready      = 1'b1;
      exp_fetch      = 32'h1c000104;
      tick();
      vectors++;
      if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000100) begin
         miscompares++;
         $display("FAIL redir_req: got en=%b addr=%h, want en=1 addr=1c000100", inst_sram_en, inst_sram_addr);
      end
      drive_edge();
      redirect_valid = 1'b0;
      fill(32'h1c000100);
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL redir_t1: got out_valid=%b, want 0", out_valid);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'h1c000100) begin
         miscompares++;
         $display("FAIL redir_t2: got v=%b pc=%h, want v=1 pc=1c000100", out_valid, out_pc);
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_back_to_back();
      drive_edge();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h1c000300;
      exp_fetch      = 32'h1c000304;
      tick();
      vectors++;
      if (inst_sram_addr !== 32'h1c000300) begin
         miscompares++;
         $display("FAIL b2b_first: got addr=%h, want 1c000300", inst_sram_addr);
      end
      drive_edge();
      redirect_pc = 32'h1c000400;
      exp_fetch   = 32'h1c000404;
      fill(32'h1c000300);
      tick();
      vectors++;
      if (out_valid !== 1'b0 || inst_sram_addr !== 32'h1c000400) begin
         miscompares++;
         $display("FAIL b2b_second: got v=%b addr=%h, want v=0 addr=1c000400", out_valid, inst_sram_addr);
      end
      drive_edge();
      redirect_valid = 1'b0;
      fill(32'h1c000400);
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_t1: got out_valid=%b, want 0", out_valid);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'h1c000400) begin
         miscompares++;
         $display("FAIL b2b_t2: got v=%b pc=%h, want v=1 pc=1c000400", out_valid, out_pc);
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_adef();
      drive_edge();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h1c000102;
      out_ready      = 1'b1;
      tick();
      vectors++;
      if (inst_sram_en !== 1'b0) begin
         miscompares++;
         $display("FAIL adef_req: got en=%b, want 0", inst_sram_en);
      end
      drive_edge();
      redirect_valid = 1'b0;
      push_adef(32'h1c000102);
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_adef !== 1'b1 || out_pc !== 32'h1c000102 || out_instr !== NOP_INSTR) begin
         miscompares++;
         $display("FAIL adef_entry: got v=%b adef=%b pc=%h instr=%h, want v=1 adef=1 pc=1c000102 instr=%h",
                  out_valid, out_adef, out_pc, out_instr, NOP_INSTR);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (inst_sram_en !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL halted c%0d: got en=%b v=%b, want en=0 v=0", i, inst_sram_en, out_valid);
         end
      end
      drive_edge();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h1c000106;
      out_ready      = 1'b0;
      tick();
      drive_edge();
      redirect_valid = 1'b0;
      push_adef(32'h1c000106);
      for (int i = 0; i < 2; i++) begin
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_adef !== 1'b1 || out_pc !== 32'h1c000106 || inst_sram_en !== 1'b0) begin
            miscompares++;
            $display("FAIL adef_halted c%0d: got v=%b adef=%b pc=%h en=%b, want v=1 adef=1 pc=1c000106 en=0",
                     i, out_valid, out_adef, out_pc, inst_sram_en);
         end
      end
      drive_edge();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h1c000200;
      out_ready      = 1'b1;
      exp_fetch      = 32'h1c000204;
      tick();
      vectors++;
      if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000200) begin
         miscompares++;
         $display("FAIL unhalt_req: got en=%b addr=%h, want en=1 addr=1c000200", inst_sram_en, inst_sram_addr);
      end
      drive_edge();
      redirect_valid = 1'b0;
      fill(32'h1c000200);
      tick();
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'h1c000200 || out_adef !== 1'b0) begin
         miscompares++;
         $display("FAIL unhalt_out: got v=%b pc=%h adef=%b, want v=1 pc=1c000200 adef=0", out_valid, out_pc, out_adef);
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_reset_midstream();
      vectors++;
      if (dut.inflight_q !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_inflight: got %b, want 1", dut.inflight_q);
      end
      drive_edge();
      reset = 1'b1;
      tick();
      vectors++;
      if (out_valid !== 1'b0 || inst_sram_en !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: got v=%b en=%b, want 0 0", out_valid, inst_sram_en);
      end
      drive_edge();
      reset = 1'b0;
      fill(RESET_PC);
      exp_fetch = RESET_PC;
      tick();
      vectors++;
      if (out_valid !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== RESET_PC) begin
         miscompares++;
         $display("FAIL mid_restart: got v=%b en=%b addr=%h, want v=0 en=1 addr=%h",
                  out_valid, inst_sram_en, inst_sram_addr, RESET_PC);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_t2: got out_valid=%b, want 0", out_valid);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin
         miscompares++;
         $display("FAIL mid_t3: got v=%b pc=%h, want v=1 pc=%h", out_valid, out_pc, RESET_PC);
      end
      for (int i = 0; i < 4; i++) tick();
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      exp_fetch      = RESET_PC;
      reset          = 1'b1;
      out_ready      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      test_reset();
      test_stall();
      test_redirect_full();
      test_back_to_back();
      test_adef();
      test_reset_midstream();
      drive_edge();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
